xbus_protocol_monitor: RTL and testbench

// - Passive, parametrised Wishbone-b4 (XBUS) protocol monitor for the neorv32 formal and simulation environment.
// - Sits beside the processor top and observes the XBUS master/slave signals; never drives the bus.
// - Tracks each transaction through an FSM, checks handshake and stability rules, and detects timeouts.
// - Reports sticky violation flags, a violation pulse and saturating transaction/error counters.

---
 rtl/xbus_protocol_monitor.sv | 168 ++++++++++++++++
 tb/tb_xbus_protocol_monitor.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/xbus_protocol_monitor.sv
// Passive Wishbone-b4 (XBUS) protocol monitor: per-transaction FSM, sticky violation flags,
// saturating counters. Define XBUS_MON_LAT_STATS_EN to add lat_min_o / lat_max_o latency statistics.
module xbus_protocol_monitor #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic [ADDR_W-1:0]   xbus_adr_o,
  input  logic [DATA_W-1:0]   xbus_dat_o,
  input  logic                xbus_we_o,
  input  logic [DATA_W/8-1:0] xbus_sel_o,
  input  logic                xbus_stb_o,
  input  logic                xbus_cyc_o,
  input  logic                xbus_ack_i,
  input  logic                xbus_err_i,
  input  logic                clr_i,
  output logic                busy_o,
  output logic [6:0]          viol_o,
  output logic                viol_pulse_o,
  output logic [CNT_W-1:0]    txn_cnt_o,
  output logic [CNT_W-1:0]    err_cnt_o
`ifdef XBUS_MON_LAT_STATS_EN
  ,
  output logic [CNT_W-1:0]    lat_min_o,
  output logic [CNT_W-1:0]    lat_max_o
`endif
);

  localparam int SEL_W = DATA_W / 8;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, BUSY, HANG} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   adr_q, adr_d;
  logic [DATA_W-1:0]   dat_q, dat_d;
  logic                we_q, we_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [CNT_W-1:0]    wait_q, wait_d, wait_inc;
  logic [6:0]          viol_q, viol_d, flags;
  logic                pulse_q, pulse_d;
  logic [CNT_W-1:0]    txn_q, txn_d, err_q, err_d;
  logic                rsp, done;

  always_comb begin
    state_d  = state_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    we_d     = we_q;
    sel_d    = sel_q;
    wait_d   = wait_q;
    flags    = '0;
    done     = 1'b0;
    rsp      = xbus_ack_i | xbus_err_i;
    // Saturating so the latency stays meaningful when the timeout check is disabled.
    wait_inc = (wait_q == CNT_MAX) ? wait_q : wait_q + CNT_W'(1);
    flags[0] = xbus_ack_i & xbus_err_i;
    flags[4] = xbus_stb_o & ~xbus_cyc_o;
    case (state_q)
      IDLE: begin
        flags[1] = rsp;
        if (xbus_stb_o && xbus_cyc_o) begin
          adr_d   = xbus_adr_o;
          dat_d   = xbus_dat_o;
          we_d    = xbus_we_o;
          sel_d   = xbus_sel_o;
          wait_d  = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        flags[2] = xbus_stb_o;
        flags[6] = xbus_cyc_o & ((xbus_adr_o != adr_q) | (xbus_we_o != we_q) |
                                 (xbus_sel_o != sel_q) | (we_q & (xbus_dat_o != dat_q)));
        if (rsp) begin
          done    = 1'b1;
          state_d = IDLE;
        end else if (!xbus_cyc_o) begin
          flags[3] = 1'b1;
          state_d  = IDLE;
        end else begin
          wait_d = wait_inc;
          if ((TIMEOUT != 0) && (wait_inc == TO_VAL)) begin
            flags[5] = 1'b1;
            state_d  = HANG;
          end
        end
      end
      HANG: begin
        flags[1] = rsp;
        if (!xbus_cyc_o) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // The pulse reflects newly raised bits even when clr_i wipes them this cycle.
    pulse_d = |(flags & ~viol_q);
    viol_d  = clr_i ? '0 : (viol_q | flags);
    txn_d   = clr_i ? '0 : ((done && txn_q != CNT_MAX) ? txn_q + CNT_W'(1) : txn_q);
    err_d   = clr_i ? '0 : ((done && xbus_err_i && err_q != CNT_MAX) ? err_q + CNT_W'(1) : err_q);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      adr_q   <= '0;
      dat_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      wait_q  <= '0;
      viol_q  <= '0;
      pulse_q <= 1'b0;
      txn_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      wait_q  <= wait_d;
      viol_q  <= viol_d;
      pulse_q <= pulse_d;
      txn_q   <= txn_d;
      err_q   <= err_d;
    end
  end

  assign busy_o       = (state_q == BUSY) || (state_q == HANG);
  assign viol_o       = viol_q;
  assign viol_pulse_o = pulse_q;
  assign txn_cnt_o    = txn_q;
  assign err_cnt_o    = err_q;

`ifdef XBUS_MON_LAT_STATS_EN
  logic [CNT_W-1:0] lat_min_q, lat_min_d, lat_max_q, lat_max_d;

  always_comb begin
    lat_min_d = lat_min_q;
    lat_max_d = lat_max_q;
    if (clr_i) begin
      lat_min_d = CNT_MAX;
      lat_max_d = '0;
    end else if (done) begin
      if (wait_inc < lat_min_q) lat_min_d = wait_inc;
      if (wait_inc > lat_max_q) lat_max_d = wait_inc;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      lat_min_q <= CNT_MAX;
      lat_max_q <= '0;
    end else begin
      lat_min_q <= lat_min_d;
      lat_max_q <= lat_max_d;
    end
  end

  assign lat_min_o = lat_min_q;
  assign lat_max_o = lat_max_q;
`endif

endmodule

// File: tb/tb_xbus_protocol_monitor.sv
// Randomised + directed bench for xbus_protocol_monitor against a transaction-level reference model.
module tb_xbus_protocol_monitor;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 4;
  localparam int SEL_W   = DATA_W / 8;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic              clk_i = 1'b0;
  logic              rstn_i = 1'b0;
  logic [ADDR_W-1:0] xbus_adr_o = '0;
  logic [DATA_W-1:0] xbus_dat_o = '0;
  logic              xbus_we_o = 1'b0;
  logic [SEL_W-1:0]  xbus_sel_o = '0;
  logic              xbus_stb_o = 1'b0;
  logic              xbus_cyc_o = 1'b0;
  logic              xbus_ack_i = 1'b0;
  logic              xbus_err_i = 1'b0;
  logic              clr_i = 1'b0;
  logic              busy_o;
  logic [6:0]        viol_o;
  logic              viol_pulse_o;
  logic [CNT_W-1:0]  txn_cnt_o, err_cnt_o;
`ifdef XBUS_MON_LAT_STATS_EN
  logic [CNT_W-1:0]  lat_min_o, lat_max_o;
`endif

  xbus_protocol_monitor #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .xbus_adr_o(xbus_adr_o), .xbus_dat_o(xbus_dat_o), .xbus_we_o(xbus_we_o),
    .xbus_sel_o(xbus_sel_o), .xbus_stb_o(xbus_stb_o), .xbus_cyc_o(xbus_cyc_o),
    .xbus_ack_i(xbus_ack_i), .xbus_err_i(xbus_err_i), .clr_i(clr_i),
    .busy_o(busy_o), .viol_o(viol_o), .viol_pulse_o(viol_pulse_o),
    .txn_cnt_o(txn_cnt_o), .err_cnt_o(err_cnt_o)
`ifdef XBUS_MON_LAT_STATS_EN
    , .lat_min_o(lat_min_o), .lat_max_o(lat_max_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: one outstanding request, a hung flag, cycles elapsed since the strobe.
  bit                m_open, m_hung;
  int                m_lat;
  logic [ADDR_W-1:0] r_adr;
  logic [DATA_W-1:0] r_dat;
  logic              r_we;
  logic [SEL_W-1:0]  r_sel;
  logic [6:0]        e_viol;
  bit                e_pulse;
  int                e_txn, e_err, e_lmin, e_lmax;

  task automatic model_reset();
    m_open = 0; m_hung = 0; m_lat = 0;
    r_adr = '0; r_dat = '0; r_we = 0; r_sel = '0;
    e_viol = '0; e_pulse = 0; e_txn = 0; e_err = 0; e_lmin = CMAX; e_lmax = 0;
  endtask

  task automatic check_outputs(input string pfx);
    check({pfx, "busy"}, busy_o, m_open || m_hung);
    check({pfx, "viol"}, viol_o, e_viol);
    check({pfx, "pulse"}, viol_pulse_o, e_pulse);
    check({pfx, "txn"}, txn_cnt_o, e_txn);
    check({pfx, "err"}, err_cnt_o, e_err);
`ifdef XBUS_MON_LAT_STATS_EN
    check({pfx, "lmin"}, lat_min_o, e_lmin);
    check({pfx, "lmax"}, lat_max_o, e_lmax);
`endif
  endtask

  task automatic step();
    logic [6:0] f;
    bit rsp, done;
    int lat;
    f = '0; done = 0; lat = 0;
    rsp = xbus_ack_i || xbus_err_i;
    if (xbus_ack_i && xbus_err_i) f[0] = 1;
    if (xbus_stb_o && !xbus_cyc_o) f[4] = 1;
    if (m_hung) begin
      if (rsp) f[1] = 1;
      if (!xbus_cyc_o) m_hung = 0;
    end else if (m_open) begin
      m_lat++;
      if (xbus_stb_o) f[2] = 1;
      if (xbus_cyc_o && (xbus_adr_o != r_adr || xbus_we_o != r_we || xbus_sel_o != r_sel ||
                         (r_we && xbus_dat_o != r_dat))) f[6] = 1;
      if (rsp) begin
        done = 1; lat = (m_lat > CMAX) ? CMAX : m_lat; m_open = 0;
      end else if (!xbus_cyc_o) begin
        f[3] = 1; m_open = 0;
      end else if (m_lat == TIMEOUT) begin
        f[5] = 1; m_open = 0; m_hung = 1;
      end
    end else begin
      if (rsp) f[1] = 1;
      if (xbus_stb_o && xbus_cyc_o) begin
        m_open = 1; m_lat = 0;
        r_adr = xbus_adr_o; r_dat = xbus_dat_o; r_we = xbus_we_o; r_sel = xbus_sel_o;
      end
    end
    e_pulse = |(f & ~e_viol);
    if (clr_i) begin
      e_viol = '0; e_txn = 0; e_err = 0; e_lmin = CMAX; e_lmax = 0;
    end else begin
      e_viol = e_viol | f;
      if (done) begin
        if (e_txn < CMAX) e_txn++;
        if (xbus_err_i && e_err < CMAX) e_err++;
        if (lat < e_lmin) e_lmin = lat;
        if (lat > e_lmax) e_lmax = lat;
      end
    end
    @(posedge clk_i);
    #1;
    check_outputs("");
  endtask

  task automatic bus_idle();
    xbus_cyc_o = 0; xbus_stb_o = 0; xbus_ack_i = 0; xbus_err_i = 0; clr_i = 0;
  endtask

  task automatic do_reset();
    rstn_i = 0;
    bus_idle();
    #1;
    model_reset();
    check_outputs("rst_");
    @(posedge clk_i);
    #1;
    rstn_i = 1;
  endtask

  task automatic clear();
    clr_i = 1; step(); clr_i = 0;
  endtask

  task automatic txn(input logic [ADDR_W-1:0] adr, input logic we, input logic [SEL_W-1:0] sel,
                     input logic [DATA_W-1:0] dat, input int lat, input bit ack, input bit err);
    xbus_adr_o = adr; xbus_we_o = we; xbus_sel_o = sel; xbus_dat_o = dat;
    xbus_cyc_o = 1; xbus_stb_o = 1; xbus_ack_i = 0; xbus_err_i = 0;
    step();
    xbus_stb_o = 0;
    for (int i = 1; i < lat; i++) step();
    xbus_ack_i = ack; xbus_err_i = err;
    step();
    xbus_ack_i = 0; xbus_err_i = 0; xbus_cyc_o = 0;
    step();
  endtask

  initial begin
    model_reset();
    do_reset();
    step();

    // Read with latency 3.
    txn(32'h100, 0, 4'hF, 32'h0, 3, 1, 0);
    check("rd_txn", txn_cnt_o, 1);
    check("rd_viol", viol_o, 0);
`ifdef XBUS_MON_LAT_STATS_EN
    check("rd_lmin", lat_min_o, 3);
    check("rd_lmax", lat_max_o, 3);
`endif
    clear();

    // Timeout after 8 silent BUSY cycles, then cyc drops out of HANG.
    xbus_adr_o = 32'h200; xbus_we_o = 0; xbus_sel_o = 4'hF;
    xbus_cyc_o = 1; xbus_stb_o = 1; step();
    xbus_stb_o = 0;
    repeat (8) step();
    check("to_flag", viol_o[5], 1);
    check("to_hang", busy_o, 1);
    xbus_cyc_o = 0; step();
    check("to_idle", busy_o, 0);
    check("to_txn", txn_cnt_o, 0);
    clear();

    // Write whose byte select changes mid-cycle.
    xbus_adr_o = 32'h40; xbus_we_o = 1; xbus_sel_o = 4'hF; xbus_dat_o = 32'hCAFE;
    xbus_cyc_o = 1; xbus_stb_o = 1; step();
    xbus_stb_o = 0; xbus_sel_o = 4'h3; step();
    step();
    xbus_ack_i = 1; step();
    xbus_ack_i = 0; xbus_cyc_o = 0; step();
    check("attr_flag", viol_o[6], 1);
    check("attr_txn", txn_cnt_o, 1);
    clear();

    // ack and err together.
    txn(32'h80, 0, 4'hF, 32'h0, 2, 1, 1);
    check("both_flag", viol_o[0], 1);
    check("both_err", err_cnt_o, 1);
    check("both_txn", txn_cnt_o, 1);
    clear();

    // Counter saturation, then clear.
    for (int i = 0; i < (1 << CNT_W) + 5; i++) txn(32'h10, 0, 4'hF, 32'h0, 1, 1, 0);
    check("sat_txn", txn_cnt_o, CMAX);
    clear();
    check("sat_clr", txn_cnt_o, 0);

    // Reset while BUSY, then a late ack.
    xbus_cyc_o = 1; xbus_stb_o = 1; step();
    xbus_stb_o = 0; step();
    do_reset();
    xbus_cyc_o = 1; xbus_ack_i = 1; step();
    check("rst_spur", viol_o[1], 1);
    check("rst_busy", busy_o, 0);
    bus_idle(); step();

    // Randomised traffic with occasional protocol abuse, clears and resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        if (xbus_cyc_o) xbus_cyc_o = ($urandom_range(0, 99) >= 10);
        else            xbus_cyc_o = ($urandom_range(0, 99) < 30);
        xbus_stb_o = xbus_cyc_o ? ($urandom_range(0, 99) < 20) : ($urandom_range(0, 99) < 3);
        xbus_ack_i = ($urandom_range(0, 99) < 15);
        xbus_err_i = ($urandom_range(0, 99) < 4);
        if ($urandom_range(0, 99) < 10) xbus_adr_o = 32'($urandom_range(0, 3) * 4);
        if ($urandom_range(0, 99) < 10) xbus_we_o = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 99) < 10) xbus_sel_o = $urandom_range(0, 1) ? 4'hF : 4'h3;
        if ($urandom_range(0, 99) < 10) xbus_dat_o = 32'($urandom_range(0, 3));
        clr_i = ($urandom_range(0, 99) < 2);
        step();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
